// File: rtl/eq_coeff_ctrl_pkg.sv
// Shared equalizer package.
//   NR_EQ_BAND_COEFF : coefficients per biquad band (b0, b1, b2, a1, a2)
//   clog2            : address-width helper usable in parameter expressions
//   eq_state_e       : state encoding of the coefficient-bank controller
package eq_coeff_ctrl_pkg;

  localparam int NR_EQ_BAND_COEFF = 5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SWAP_WAIT = 2'd1,
    ST_COPY      = 2'd2
  } eq_state_e;

  // Never returns less than 1 so that a one-word memory still gets an address bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/coeff_bank_1w2r.sv
// One coefficient bank: DEPTH words of WIDTH bits, one write port and two
// independent registered read ports.
//   clk, rst_n         : clock, async active-low reset (read registers only)
//   we, waddr, wdata   : write port; writes at or beyond DEPTH are ignored
//   raddr_a / rdata_a  : read port A, rdata_a(t+1) = mem[raddr_a(t)]
//   raddr_b / rdata_b  : read port B, same timing as port A
// Reads at or beyond DEPTH return 0. The storage itself has no reset.
module coeff_bank_1w2r #(
  parameter int DEPTH = 160,
  parameter int WIDTH = 32,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             w_ok;
  logic             a_ok;
  logic             b_ok;

  assign w_ok = {1'b0, waddr}   < DEPTH_C;
  assign a_ok = {1'b0, raddr_a} < DEPTH_C;
  assign b_ok = {1'b0, raddr_b} < DEPTH_C;

  always_ff @(posedge clk) begin
    if (we && w_ok) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= a_ok ? mem[raddr_a] : '0;
      rdata_b <= b_ok ? mem[raddr_b] : '0;
    end
  end

endmodule

// File: rtl/eq_coeff_ctrl.sv
// Double-buffered equalizer coefficient store.
// The equalizer reads the active bank; the host writes only the shadow bank.
// A swap request waits until the equalizer is idle, flips bank_sel, then
// copies the new active bank into the new shadow bank so the host always
// edits a full, current coefficient set.
//   eq_coeff_addr / eq_coeff   : equalizer read, 1-clock latency, 0 if out of range
//   eq_s_dv, eq_s_dr           : equalizer input handshake copies (idle = dr && !dv)
//   s_cfg_d/addr/dv/dr         : host write channel into the shadow bank
//   cfg_swap                   : swap request pulse
//   swap_pending, swap_done    : swap status (done is a one-cycle pulse)
//   bank_sel                   : active bank index
//   cfg_err                    : one-cycle pulse after an out-of-range host write
//
// Host handshake: a word transfers on every rising edge where s_cfg_dv and
// s_cfg_dr are both high; s_cfg_dr is high only in IDLE, and s_cfg_dv may be
// asserted regardless of s_cfg_dr.
module eq_coeff_ctrl
  import eq_coeff_ctrl_pkg::*;
#(
  parameter  int NR_CHANNELS    = 4,
  parameter  int NR_EQ_BANDS    = 8,
  parameter  int EQ_COEFF_WIDTH = 32,
  localparam int NR_EQ_COEFF    = NR_CHANNELS * NR_EQ_BANDS * NR_EQ_BAND_COEFF,
  localparam int ADDR_W         = clog2(NR_EQ_COEFF)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         eq_coeff_addr,
  output logic [EQ_COEFF_WIDTH-1:0] eq_coeff,
  input  logic                      eq_s_dv,
  input  logic                      eq_s_dr,
  input  logic [EQ_COEFF_WIDTH-1:0] s_cfg_d,
  input  logic [ADDR_W-1:0]         s_cfg_addr,
  input  logic                      s_cfg_dv,
  output logic                      s_cfg_dr,
  input  logic                      cfg_swap,
  output logic                      swap_pending,
  output logic                      swap_done,
  output logic                      bank_sel,
  output logic                      cfg_err
);

  localparam logic [ADDR_W:0] NR_COEFF_C = (ADDR_W+1)'(NR_EQ_COEFF);

  eq_state_e                 state;
  // One bit wider than the address so it can reach NR_EQ_COEFF.
  logic [ADDR_W:0]           copy_cnt;
  logic                      rd_sel_q;

  logic                      host_wr;
  logic                      host_in_range;
  logic [ADDR_W-1:0]         copy_raddr;
  logic [ADDR_W-1:0]         copy_waddr;
  logic                      shadow_we;
  logic [ADDR_W-1:0]         shadow_waddr;
  logic [EQ_COEFF_WIDTH-1:0] shadow_wdata;
  logic                      we0;
  logic                      we1;
  logic [EQ_COEFF_WIDTH-1:0] rd_a0;
  logic [EQ_COEFF_WIDTH-1:0] rd_a1;
  logic [EQ_COEFF_WIDTH-1:0] rd_b0;
  logic [EQ_COEFF_WIDTH-1:0] rd_b1;

  assign host_wr       = s_cfg_dv && s_cfg_dr;
  assign host_in_range = {1'b0, s_cfg_addr} < NR_COEFF_C;

  // Copy pipeline: at count k the read of word k is issued on port B and the
  // word read at count k-1 is written, so word N-1 lands at count N.
  assign copy_raddr = copy_cnt[ADDR_W-1:0];
  assign copy_waddr = copy_cnt[ADDR_W-1:0] - ADDR_W'(1);

  always_comb begin
    shadow_we    = 1'b0;
    shadow_waddr = '0;
    shadow_wdata = '0;
    if (host_wr && host_in_range) begin
      shadow_we    = 1'b1;
      shadow_waddr = s_cfg_addr;
      shadow_wdata = s_cfg_d;
    end else if (state == ST_COPY && copy_cnt != '0) begin
      shadow_we    = 1'b1;
      shadow_waddr = copy_waddr;
      shadow_wdata = bank_sel ? rd_b1 : rd_b0;
    end
  end

  // Only the shadow bank (index !bank_sel) is ever written.
  assign we0 = shadow_we &&  bank_sel;
  assign we1 = shadow_we && !bank_sel;

  coeff_bank_1w2r #(
    .DEPTH (NR_EQ_COEFF),
    .WIDTH (EQ_COEFF_WIDTH),
    .AW    (ADDR_W)
  ) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we0),
    .waddr   (shadow_waddr),
    .wdata   (shadow_wdata),
    .raddr_a (eq_coeff_addr),
    .rdata_a (rd_a0),
    .raddr_b (copy_raddr),
    .rdata_b (rd_b0)
  );

  coeff_bank_1w2r #(
    .DEPTH (NR_EQ_COEFF),
    .WIDTH (EQ_COEFF_WIDTH),
    .AW    (ADDR_W)
  ) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we1),
    .waddr   (shadow_waddr),
    .wdata   (shadow_wdata),
    .raddr_a (eq_coeff_addr),
    .rdata_a (rd_a1),
    .raddr_b (copy_raddr),
    .rdata_b (rd_b1)
  );

  // Remember which bank served the read launched last cycle, so a bank flip
  // on the same edge cannot redirect a read already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_sel_q <= 1'b0;
    else        rd_sel_q <= bank_sel;
  end

  assign eq_coeff = rd_sel_q ? rd_a1 : rd_a0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bank_sel     <= 1'b0;
      s_cfg_dr     <= 1'b1;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
      cfg_err      <= 1'b0;
      copy_cnt     <= '0;
    end else begin
      swap_done <= 1'b0;
      cfg_err   <= host_wr && !host_in_range;
      case (state)
        ST_IDLE: begin
          if (cfg_swap) begin
            swap_pending <= 1'b1;
            s_cfg_dr     <= 1'b0;
            state        <= ST_SWAP_WAIT;
          end
        end
        ST_SWAP_WAIT: begin
          // Flip only between samples so one sample never mixes banks.
          if (eq_s_dr && !eq_s_dv) begin
            bank_sel     <= ~bank_sel;
            swap_pending <= 1'b0;
            copy_cnt     <= '0;
            state        <= ST_COPY;
          end
        end
        ST_COPY: begin
          if (copy_cnt == NR_COEFF_C) begin
            copy_cnt  <= '0;
            swap_done <= 1'b1;
            s_cfg_dr  <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            copy_cnt <= copy_cnt + (ADDR_W+1)'(1);
          end
        end
        default: begin
          s_cfg_dr <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq_coeff_ctrl.sv
// Bench for eq_coeff_ctrl with NR_CHANNELS=2, NR_EQ_BANDS=2 (20 words, 5-bit address).
// A reference copy of both banks tracks host writes, swaps and copies; every
// equalizer read pushes its expected word into exp_q and the next clock pops it.
module tb_eq_coeff_ctrl;

  localparam int N  = 20;
  localparam int AW = 5;
  localparam int W  = 32;

  typedef struct {
    bit          is_wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          exp_err;
    logic [W-1:0]  exp_rd;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] eq_coeff_addr;
  logic [W-1:0]  eq_coeff;
  logic          eq_s_dv;
  logic          eq_s_dr;
  logic [W-1:0]  s_cfg_d;
  logic [AW-1:0] s_cfg_addr;
  logic          s_cfg_dv;
  logic          s_cfg_dr;
  logic          cfg_swap;
  logic          swap_pending;
  logic          swap_done;
  logic          bank_sel;
  logic          cfg_err;

  int            checks;
  int            errors;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  mdl [2][N];
  bit            mdl_sel;
  vec_t          tbl [11];

  eq_coeff_ctrl #(
    .NR_CHANNELS    (2),
    .NR_EQ_BANDS    (2),
    .EQ_COEFF_WIDTH (W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .eq_coeff_addr (eq_coeff_addr),
    .eq_coeff      (eq_coeff),
    .eq_s_dv       (eq_s_dv),
    .eq_s_dr       (eq_s_dr),
    .s_cfg_d       (s_cfg_d),
    .s_cfg_addr    (s_cfg_addr),
    .s_cfg_dv      (s_cfg_dv),
    .s_cfg_dr      (s_cfg_dr),
    .cfg_swap      (cfg_swap),
    .swap_pending  (swap_pending),
    .swap_done     (swap_done),
    .bank_sel      (bank_sel),
    .cfg_err       (cfg_err)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock; outputs sampled 1 ns after the edge; pending read compared.
  task automatic step();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("eq_coeff_rd", eq_coeff, e);
    end
  endtask

  task automatic issue_read(input logic [AW-1:0] a);
    eq_coeff_addr = a;
    exp_q.push_back((a < N) ? mdl[mdl_sel][a] : '0);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    chk("wr_ready", {31'b0, s_cfg_dr}, 1);
    s_cfg_addr = a;
    s_cfg_d    = d;
    s_cfg_dv   = 1'b1;
    step();
    s_cfg_dv = 1'b0;
    if (a < N) mdl[!mdl_sel][a] = d;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < N; i++) begin
      issue_read(AW'(i));
      step();
    end
    issue_read(5'd25);
    step();
    if (errors > 0) $display("note: errors so far after %s sweep: %0d", tag, errors);
  endtask

  // Swap driver. hold: busy cycles before the equalizer goes idle;
  // wr: host write in the same cycle as cfg_swap; rst_at: COPY cycle at
  // which reset is asserted (-1 for none).
  task automatic do_swap(input int hold, input bit wr, input logic [AW-1:0] wa,
                         input logic [W-1:0] wd, input int rst_at);
    bit old_sel;
    int n;
    old_sel = mdl_sel;
    chk("swap_req_ready", {31'b0, s_cfg_dr}, 1);
    cfg_swap = 1'b1;
    eq_s_dv  = 1'b0;
    eq_s_dr  = (hold == 0);
    if (wr) begin
      s_cfg_addr = wa;
      s_cfg_d    = wd;
      s_cfg_dv   = 1'b1;
    end
    step();
    cfg_swap = 1'b0;
    s_cfg_dv = 1'b0;
    if (wr && wa < N) mdl[!old_sel][wa] = wd;
    chk("swap_pending_set", {31'b0, swap_pending}, 1);
    chk("wait_dr_low", {31'b0, s_cfg_dr}, 0);
    for (int k = 0; k < hold; k++) begin
      eq_s_dr  = (k >= hold / 2);
      eq_s_dv  = (k >= hold / 2);
      cfg_swap = (k == 3);
      step();
      chk("wait_bank_sel", {31'b0, bank_sel}, {31'b0, old_sel});
      chk("wait_pending", {31'b0, swap_pending}, 1);
      chk("wait_dr", {31'b0, s_cfg_dr}, 0);
    end
    cfg_swap = 1'b0;
    eq_s_dr  = 1'b1;
    eq_s_dv  = 1'b0;
    step();
    chk("swap_bank_sel", {31'b0, bank_sel}, {31'b0, !old_sel});
    chk("swap_pending_clr", {31'b0, swap_pending}, 0);
    mdl_sel = !old_sel;
    for (int i = 0; i < N; i++) mdl[!mdl_sel][i] = mdl[mdl_sel][i];
    n = 0;
    while (swap_done !== 1'b1 && n < 100) begin
      cfg_swap = (n == 5);
      if (rst_at >= 0 && n == rst_at) begin
        cfg_swap = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_eq_coeff", eq_coeff, 0);
        chk("rst_bank_sel", {31'b0, bank_sel}, 0);
        chk("rst_dr", {31'b0, s_cfg_dr}, 1);
        chk("rst_pending", {31'b0, swap_pending}, 0);
        chk("rst_done", {31'b0, swap_done}, 0);
        chk("rst_err", {31'b0, cfg_err}, 0);
        mdl_sel = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_dr", {31'b0, s_cfg_dr}, 1);
        chk("post_rst_bank_sel", {31'b0, bank_sel}, 0);
        chk("post_rst_done", {31'b0, swap_done}, 0);
        return;
      end
      step();
      n++;
      if (n == 10) chk("copy_dr", {31'b0, s_cfg_dr}, 0);
    end
    cfg_swap = 1'b0;
    chk("swap_done_latency", n, 21);
    chk("done_dr", {31'b0, s_cfg_dr}, 1);
    step();
    chk("done_one_cycle", {31'b0, swap_done}, 0);
    chk("swap_not_queued", {31'b0, swap_pending}, 0);
    chk("idle_dr", {31'b0, s_cfg_dr}, 1);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [W-1:0] d;
    checks = 0;
    errors = 0;
    mdl_sel = 1'b0;

    //            is_wr addr   data          err   exp_rd
    tbl[0]  = '{1'b0, 5'd3,  32'h0,        1'b0, 32'h12345678};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 32'hC0EF0000};
    tbl[2]  = '{1'b0, 5'd19, 32'h0,        1'b0, 32'hC0EF0013};
    tbl[3]  = '{1'b0, 5'd20, 32'h0,        1'b0, 32'h00000000};
    tbl[4]  = '{1'b0, 5'd25, 32'h0,        1'b0, 32'h00000000};
    tbl[5]  = '{1'b0, 5'd31, 32'h0,        1'b0, 32'h00000000};
    tbl[6]  = '{1'b1, 5'd25, 32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[7]  = '{1'b1, 5'd31, 32'h00000001, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 5'd4,  32'hDEADBEEF, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 5'd4,  32'h0,        1'b0, 32'hC0EF0004};
    tbl[10] = '{1'b0, 5'd7,  32'h0,        1'b0, 32'hC0EF0007};

    rst_n = 1'b0;
    eq_coeff_addr = '0;
    eq_s_dv = 1'b0;
    eq_s_dr = 1'b1;
    s_cfg_d = '0;
    s_cfg_addr = '0;
    s_cfg_dv = 1'b0;
    cfg_swap = 1'b0;

    #12;
    chk("reset_eq_coeff", eq_coeff, 0);
    chk("reset_bank_sel", {31'b0, bank_sel}, 0);
    chk("reset_dr", {31'b0, s_cfg_dr}, 1);
    chk("reset_pending", {31'b0, swap_pending}, 0);
    chk("reset_done", {31'b0, swap_done}, 0);
    chk("reset_err", {31'b0, cfg_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Fill the shadow bank completely, then swap with an idle equalizer.
    for (int i = 0; i < N; i++) begin
      host_write(AW'(i), (i == 3) ? 32'h12345678 : (32'hC0EF0000 | W'(i)));
      chk("init_err", {31'b0, cfg_err}, 0);
    end
    do_swap(0, 1'b0, '0, '0, -1);
    chk("bank_sel_after_first_swap", {31'b0, bank_sel}, 1);

    // Table of reads and host writes against the known active bank.
    for (int v = 0; v < 11; v++) begin
      if (tbl[v].is_wr) begin
        host_write(tbl[v].addr, tbl[v].data);
        chk("tbl_cfg_err", {31'b0, cfg_err}, {31'b0, tbl[v].exp_err});
        if (tbl[v].exp_err) begin
          step();
          chk("tbl_cfg_err_once", {31'b0, cfg_err}, 0);
        end
      end else begin
        eq_coeff_addr = tbl[v].addr;
        exp_q.push_back(tbl[v].exp_rd);
        step();
      end
    end

    // Only addr 4 rewritten; swap must keep addr 3 via the copy.
    do_swap(0, 1'b0, '0, '0, -1);
    eq_coeff_addr = 5'd3;
    exp_q.push_back(32'h12345678);
    step();
    eq_coeff_addr = 5'd4;
    exp_q.push_back(32'hDEADBEEF);
    step();
    issue_read(5'd5);
    step();

    // Shadow writes every cycle while the equalizer reads the active bank.
    for (int i = 0; i < N; i++) begin
      d = $urandom;
      s_cfg_addr = AW'(i);
      s_cfg_d    = d;
      s_cfg_dv   = 1'b1;
      issue_read(AW'($urandom_range(0, N - 1)));
      step();
      mdl[!mdl_sel][i] = d;
    end
    s_cfg_dv = 1'b0;

    // Busy equalizer for 50 cycles, write in the same cycle as cfg_swap.
    do_swap(50, 1'b1, 5'd10, 32'hA5A5A5A5, -1);
    eq_coeff_addr = 5'd10;
    exp_q.push_back(32'hA5A5A5A5);
    step();
    sweep("hold_swap");

    // Back to bank 0, then swap to bank 1 and reset in COPY cycle 10.
    do_swap(0, 1'b0, '0, '0, -1);
    do_swap(0, 1'b0, '0, '0, 10);
    sweep("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
